// File: rtl/wave_seq_ctrl_if.sv
// Bundle between host/config logic, the trapezoid ramp engine and wave_seq_ctrl.
// cmd_valid/cmd_ready: a command moves on a rising edge where both are high; the host
// may hold cmd_valid high across cycles; cmd_ready is combinational from the FIFO count.
interface wave_seq_ctrl_if #(
  parameter int DW    = 9,
  parameter int HW    = 8,
  parameter int RW    = 4,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          cmd_valid;
  logic          cmd_ready;
  logic [DW-1:0] cmd_peak;
  logic [HW-1:0] cmd_hold;
  logic [RW-1:0] cmd_rpt;
  logic          abort;
  logic          seg_start;
  logic [1:0]    seg_mode;
  logic [DW-1:0] seg_target;
  logic [HW-1:0] seg_hold;
  logic          seg_done;
  logic          seg_abort;
  logic          busy;
  logic          cmd_done;
  logic [CW-1:0] fifo_count;
  logic [1:0]    state_dbg;

  modport master (
    output cmd_valid, cmd_peak, cmd_hold, cmd_rpt, abort, seg_done,
    input  cmd_ready, seg_start, seg_mode, seg_target, seg_hold, seg_abort,
           busy, cmd_done, fifo_count, state_dbg
  );

  modport slave (
    input  cmd_valid, cmd_peak, cmd_hold, cmd_rpt, abort, seg_done,
    output cmd_ready, seg_start, seg_mode, seg_target, seg_hold, seg_abort,
           busy, cmd_done, fifo_count, state_dbg
  );
endinterface

// File: rtl/wave_seq_ctrl.sv
// Command sequencer for the trapezoid ramp engine: queues commands and walks the engine
// through rise, top hold, fall, bottom hold for each requested period.
module wave_seq_ctrl #(
  parameter int DW    = 9,
  parameter int HW    = 8,
  parameter int RW    = 4,
  parameter int DEPTH = 4
) (
  input logic           clk,
  input logic           res,
  wave_seq_ctrl_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t        state, state_next;

  logic [DW-1:0] mem_peak [DEPTH];
  logic [HW-1:0] mem_hold [DEPTH];
  logic [RW-1:0] mem_rpt  [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push, pop;

  logic [DW-1:0] cur_peak;
  logic [HW-1:0] cur_hold;
  logic [RW-1:0] rpt_left, rpt_next;
  logic [1:0]    mode, mode_next;
  logic          start_next, abort_pulse_next, done_next;

  assign bus.cmd_ready  = (count < CW'(DEPTH));
  assign push           = bus.cmd_valid && bus.cmd_ready && !bus.abort;
  assign bus.fifo_count = count;
  assign bus.busy       = (state != S_IDLE);
  assign bus.state_dbg  = state;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (bus.abort) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_peak[wr_ptr] <= bus.cmd_peak;
      mem_hold[wr_ptr] <= bus.cmd_hold;
      mem_rpt[wr_ptr]  <= bus.cmd_rpt;
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) state <= S_IDLE;
    else     state <= state_next;
  end

  // seg_done is ignored while seg_start is still high so a stale done from the
  // previous segment cannot retire the one just issued.
  always_comb begin
    state_next       = state;
    mode_next        = mode;
    rpt_next         = rpt_left;
    pop              = 1'b0;
    start_next       = 1'b0;
    abort_pulse_next = 1'b0;
    done_next        = 1'b0;
    if (bus.abort) begin
      state_next       = S_IDLE;
      abort_pulse_next = (state != S_IDLE);
    end else begin
      case (state)
        S_IDLE: begin
          if (count != '0) begin
            pop        = 1'b1;
            mode_next  = 2'd0;
            rpt_next   = mem_rpt[rd_ptr];
            state_next = S_ISSUE;
          end
        end
        S_ISSUE: begin
          start_next = 1'b1;
          state_next = S_WAIT;
        end
        S_WAIT: begin
          if (bus.seg_done && !bus.seg_start) begin
            if (mode != 2'd3) begin
              mode_next  = mode + 2'd1;
              state_next = S_ISSUE;
            end else if (rpt_left != '0) begin
              rpt_next   = rpt_left - RW'(1);
              mode_next  = 2'd0;
              state_next = S_ISSUE;
            end else begin
              done_next  = 1'b1;
              state_next = S_IDLE;
            end
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Segment fields are captured together with seg_start and held until the next issue.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      cur_peak       <= '0;
      cur_hold       <= '0;
      rpt_left       <= '0;
      mode           <= 2'd0;
      bus.seg_start  <= 1'b0;
      bus.seg_abort  <= 1'b0;
      bus.cmd_done   <= 1'b0;
      bus.seg_mode   <= 2'd0;
      bus.seg_target <= '0;
      bus.seg_hold   <= '0;
    end else begin
      mode          <= mode_next;
      rpt_left      <= rpt_next;
      bus.seg_start <= start_next;
      bus.seg_abort <= abort_pulse_next;
      bus.cmd_done  <= done_next;
      if (pop) begin
        cur_peak <= mem_peak[rd_ptr];
        cur_hold <= mem_hold[rd_ptr];
      end
      if (start_next) begin
        bus.seg_mode   <= mode;
        bus.seg_target <= mode[1] ? '0 : cur_peak;
        bus.seg_hold   <= mode[0] ? cur_hold : '0;
      end
    end
  end
endmodule

// File: tb/tb_wave_seq_ctrl.sv
// Self-checking bench for wave_seq_ctrl: a 3-cycle engine model answers each segment,
// and expected segment fields are queued per accepted command and matched on seg_start.
module tb_wave_seq_ctrl;
  localparam int DW    = 9;
  localparam int HW    = 8;
  localparam int RW    = 4;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int W     = 2 + DW + HW;
  localparam int OW    = 6 + DW + HW + CW;

  logic clk = 1'b0;
  logic res = 1'b1;

  wave_seq_ctrl_if #(.DW(DW), .HW(HW), .RW(RW), .DEPTH(DEPTH)) bus ();

  wave_seq_ctrl #(.DW(DW), .HW(HW), .RW(RW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int n_start = 0;
  int n_done = 0;
  int start_cyc = 0;
  int done_cyc = 0;
  int last_push_cyc = 0;

  logic eng_en = 1'b0;
  logic eng_pulse = 1'b0;
  logic man_done = 1'b0;
  int   eng_cnt = 0;

  assign bus.seg_done = eng_pulse | man_done;

  // Engine model: seg_done pulses 3 cycles after each seg_start.
  always @(negedge clk) begin
    if (res || !eng_en) begin
      eng_cnt   <= 0;
      eng_pulse <= 1'b0;
    end else if (bus.seg_start) begin
      eng_cnt   <= 3;
      eng_pulse <= 1'b0;
    end else begin
      eng_pulse <= (eng_cnt == 1);
      eng_cnt   <= (eng_cnt != 0) ? eng_cnt - 1 : 0;
    end
  end

  function automatic logic [OW-1:0] outs_now();
    return {bus.seg_start, bus.seg_mode, bus.seg_target, bus.seg_hold,
            bus.seg_abort, bus.busy, bus.cmd_done, bus.fifo_count};
  endfunction

  // One cycle; scoreboard matches every seg_start against the expected queue.
  task automatic tick();
    logic [W-1:0] e;
    @(negedge clk);
    cyc++;
    if (bus.seg_start === 1'b1) begin
      n_start++;
      start_cyc = cyc;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL seg_start_unexpected: got mode=%0d target=%0d hold=%0d, expected no segment",
                 bus.seg_mode, bus.seg_target, bus.seg_hold);
      end else begin
        e = exp_q.pop_front();
        if ({bus.seg_mode, bus.seg_target, bus.seg_hold} !== e) begin
          n_err++;
          $display("FAIL seg_fields: got mode=%0d target=%0d hold=%0d, expected mode=%0d target=%0d hold=%0d",
                   bus.seg_mode, bus.seg_target, bus.seg_hold,
                   e[W-1 -: 2], e[HW+DW-1 -: DW], e[HW-1:0]);
        end
      end
    end
    if (bus.cmd_done === 1'b1) begin
      n_done++;
      done_cyc = cyc;
    end
  endtask

  task automatic push_cmd(input int peak, input int hold, input int rpt, output bit acc);
    bus.cmd_valid = 1'b1;
    bus.cmd_peak  = DW'(peak);
    bus.cmd_hold  = HW'(hold);
    bus.cmd_rpt   = RW'(rpt);
    acc = bus.cmd_ready;
    if (acc) begin
      for (int p = 0; p <= rpt; p++) begin
        exp_q.push_back({2'd0, DW'(peak), HW'(0)});
        exp_q.push_back({2'd1, DW'(peak), HW'(hold)});
        exp_q.push_back({2'd2, DW'(0), HW'(0)});
        exp_q.push_back({2'd3, DW'(0), HW'(hold)});
      end
    end
    last_push_cyc = cyc;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic do_abort(input bit with_push);
    bus.abort = 1'b1;
    if (with_push) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_peak  = DW'(77);
      bus.cmd_hold  = HW'(1);
      bus.cmd_rpt   = RW'(0);
    end
    tick();
    bus.abort     = 1'b0;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if (outs_now() !== '0) begin
      n_err++; $display("FAIL reset_outputs: got %h, expected 0", outs_now());
    end
    n_cmp++;
    if (bus.cmd_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_cmd_ready: got %b, expected 1", bus.cmd_ready);
    end
    res = 1'b0;
    tick();
    n_cmp++;
    if (bus.state_dbg !== 2'd0) begin
      n_err++; $display("FAIL reset_state: got %0d, expected 0", bus.state_dbg);
    end
  endtask

  task automatic test_single();
    bit acc;
    int s0, d0, pc, first, prev, seen;
    eng_en = 1'b1;
    s0 = n_start; d0 = n_done; first = -1; prev = -1; seen = n_start;
    push_cmd(299, 200, 1, acc);
    pc = last_push_cyc;
    for (int i = 0; i < 300 && n_done == d0; i++) begin
      tick();
      if (n_start != seen) begin
        seen = n_start;
        if (first < 0) first = start_cyc;
        if (prev >= 0) begin
          n_cmp++;
          if (start_cyc - prev !== 5) begin
            n_err++; $display("FAIL seg_gap: got %0d cycles, expected 5", start_cyc - prev);
          end
        end
        prev = start_cyc;
      end
    end
    n_cmp++;
    if (acc !== 1'b1) begin n_err++; $display("FAIL single_accept: got %b, expected 1", acc); end
    n_cmp++;
    if (first !== pc + 3) begin
      n_err++; $display("FAIL pop_latency: got first start at %0d, expected %0d", first, pc + 3);
    end
    n_cmp++;
    if (n_start - s0 !== 8) begin n_err++; $display("FAIL single_starts: got %0d, expected 8", n_start - s0); end
    n_cmp++;
    if (n_done - d0 !== 1) begin n_err++; $display("FAIL single_done: got %0d, expected 1", n_done - d0); end
    n_cmp++;
    if (bus.busy !== 1'b0) begin n_err++; $display("FAIL single_busy: got %b, expected 0", bus.busy); end
    tick();
    n_cmp++;
    if (bus.cmd_done !== 1'b0) begin n_err++; $display("FAIL cmd_done_width: got %b, expected 0", bus.cmd_done); end
    n_cmp++;
    if (exp_q.size() !== 0) begin n_err++; $display("FAIL single_leftover: got %0d, expected 0", exp_q.size()); end
  endtask

  task automatic test_stall();
    bit acc, acc6;
    int acc_cnt, s0;
    eng_en = 1'b0; acc_cnt = 0; s0 = n_start;
    for (int i = 0; i < 5; i++) begin
      push_cmd(10 + i, i, 0, acc);
      acc_cnt += int'(acc);
    end
    push_cmd(99, 9, 0, acc6);
    n_cmp++;
    if (acc_cnt !== 5) begin n_err++; $display("FAIL stall_accepted: got %0d, expected 5", acc_cnt); end
    n_cmp++;
    if (acc6 !== 1'b0) begin n_err++; $display("FAIL stall_sixth: got %b, expected 0", acc6); end
    n_cmp++;
    if (bus.fifo_count !== CW'(4)) begin n_err++; $display("FAIL stall_count: got %0d, expected 4", bus.fifo_count); end
    n_cmp++;
    if (bus.cmd_ready !== 1'b0) begin n_err++; $display("FAIL stall_ready: got %b, expected 0", bus.cmd_ready); end
    repeat (3) tick();
    n_cmp++;
    if (n_start - s0 !== 1) begin n_err++; $display("FAIL stall_starts: got %0d, expected 1", n_start - s0); end
    do_abort(1'b0);
    exp_q.delete();
    n_cmp++;
    if ({bus.seg_abort, bus.busy, bus.fifo_count} !== {1'b1, 1'b0, CW'(0)}) begin
      n_err++; $display("FAIL stall_flush: got abort=%b busy=%b count=%0d, expected 1 0 0",
                        bus.seg_abort, bus.busy, bus.fifo_count);
    end
  endtask

  task automatic test_abort();
    bit acc;
    int s1, d0;
    eng_en = 1'b0;
    for (int i = 0; i < 4; i++) push_cmd(200 + i, 3, 2, acc);
    repeat (3) tick();
    n_cmp++;
    if ({bus.state_dbg, bus.fifo_count} !== {2'd2, CW'(3)}) begin
      n_err++; $display("FAIL abort_setup: got state=%0d count=%0d, expected 2 3", bus.state_dbg, bus.fifo_count);
    end
    d0 = n_done;
    do_abort(1'b1);
    exp_q.delete();
    s1 = n_start;
    n_cmp++;
    if (bus.seg_abort !== 1'b1) begin n_err++; $display("FAIL abort_pulse: got %b, expected 1", bus.seg_abort); end
    n_cmp++;
    if (bus.fifo_count !== CW'(0)) begin n_err++; $display("FAIL abort_count: got %0d, expected 0", bus.fifo_count); end
    n_cmp++;
    if (bus.busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b, expected 0", bus.busy); end
    n_cmp++;
    if (bus.cmd_done !== 1'b0) begin n_err++; $display("FAIL abort_cmd_done: got %b, expected 0", bus.cmd_done); end
    tick();
    n_cmp++;
    if (bus.seg_abort !== 1'b0) begin n_err++; $display("FAIL abort_width: got %b, expected 0", bus.seg_abort); end
    repeat (5) tick();
    n_cmp++;
    if ({n_start - s1, n_done - d0, 32'(bus.fifo_count)} !== {32'd0, 32'd0, 32'd0}) begin
      n_err++; $display("FAIL abort_quiet: got starts=%0d dones=%0d count=%0d, expected 0 0 0",
                        n_start - s1, n_done - d0, bus.fifo_count);
    end
    do_abort(1'b0);
    n_cmp++;
    if (bus.seg_abort !== 1'b0) begin n_err++; $display("FAIL abort_idle: got %b, expected 0", bus.seg_abort); end
  endtask

  task automatic test_spurious_done();
    bit acc;
    int s0;
    eng_en = 1'b0; s0 = n_start;
    man_done = 1'b1;
    tick(); tick();
    man_done = 1'b0;
    tick();
    n_cmp++;
    if ({bus.busy, bus.state_dbg, 32'(n_start - s0)} !== {1'b0, 2'd0, 32'd0}) begin
      n_err++; $display("FAIL done_in_idle: got busy=%b state=%0d starts=%0d, expected 0 0 0",
                        bus.busy, bus.state_dbg, n_start - s0);
    end
    push_cmd(40, 6, 0, acc);
    tick();
    man_done = 1'b1;
    tick();
    tick();
    man_done = 1'b0;
    repeat (4) tick();
    n_cmp++;
    if (n_start - s0 !== 1) begin n_err++; $display("FAIL done_in_issue_starts: got %0d, expected 1", n_start - s0); end
    n_cmp++;
    if ({bus.state_dbg, bus.seg_mode} !== {2'd2, 2'd0}) begin
      n_err++; $display("FAIL done_in_issue_state: got state=%0d mode=%0d, expected 2 0", bus.state_dbg, bus.seg_mode);
    end
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    for (int i = 0; i < 10 && n_start - s0 < 2; i++) tick();
    n_cmp++;
    if (n_start - s0 !== 2) begin n_err++; $display("FAIL done_in_wait: got %0d starts, expected 2", n_start - s0); end
    do_abort(1'b0);
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    bit acc, found;
    int s0, d0;
    eng_en = 1'b1; found = 1'b0;
    push_cmd(50, 10, 0, acc);
    for (int i = 0; i < 100 && !found; i++) begin
      tick();
      if (bus.seg_start === 1'b1 && bus.seg_mode === 2'd2) found = 1'b1;
    end
    n_cmp++;
    if (found !== 1'b1) begin n_err++; $display("FAIL reset_mid_reach: got %b, expected 1", found); end
    tick();
    res = 1'b1;
    #1;
    n_cmp++;
    if (outs_now() !== '0) begin n_err++; $display("FAIL reset_mid_outputs: got %h, expected 0", outs_now()); end
    n_cmp++;
    if (bus.cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_mid_ready: got %b, expected 1", bus.cmd_ready); end
    tick(); tick();
    res = 1'b0;
    exp_q.delete();
    s0 = n_start; d0 = n_done;
    push_cmd(7, 3, 0, acc);
    for (int i = 0; i < 100 && n_done == d0; i++) tick();
    n_cmp++;
    if ({acc, 32'(n_start - s0), 32'(n_done - d0)} !== {1'b1, 32'd4, 32'd1}) begin
      n_err++; $display("FAIL reset_mid_restart: got acc=%b starts=%0d dones=%0d, expected 1 4 1",
                        acc, n_start - s0, n_done - d0);
    end
  endtask

  task automatic test_back_to_back();
    bit a, b;
    int d0, dc, sb;
    eng_en = 1'b1; d0 = n_done;
    push_cmd(120, 2, 0, a);
    push_cmd(0, 0, 0, b);
    n_cmp++;
    if ({a, b} !== 2'b11) begin n_err++; $display("FAIL b2b_accept: got %b, expected 11", {a, b}); end
    for (int i = 0; i < 200 && n_done == d0; i++) tick();
    dc = done_cyc; sb = n_start;
    for (int i = 0; i < 10 && n_start == sb; i++) tick();
    n_cmp++;
    if (start_cyc - dc !== 2) begin n_err++; $display("FAIL b2b_gap: got %0d cycles, expected 2", start_cyc - dc); end
    for (int i = 0; i < 200 && n_done - d0 < 2; i++) tick();
    n_cmp++;
    if (n_done - d0 !== 2) begin n_err++; $display("FAIL b2b_done: got %0d, expected 2", n_done - d0); end
    n_cmp++;
    if ({bus.busy, 32'(exp_q.size())} !== {1'b0, 32'd0}) begin
      n_err++; $display("FAIL b2b_end: got busy=%b left=%0d, expected 0 0", bus.busy, exp_q.size());
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_peak  = '0;
    bus.cmd_hold  = '0;
    bus.cmd_rpt   = '0;
    bus.abort     = 1'b0;
    test_reset();
    test_single();
    test_stall();
    test_abort();
    test_spurious_done();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
